// File: rtl/shift_ctrl.sv
// Sequencer driving an attached shift_reg for serial TX (load + shift out) or RX (shift in + capture).
// Latency: TX busy for WIDTH+2 cycles after the start edge, RX for WIDTH+1; rx_data_o valid one cycle after DONE.
// Backpressure: none; start_i is sampled only in IDLE and ignored while busy.
//
// Ports:
//   clk, nrst         clock and asynchronous active-low reset
//   start_i           request an operation (IDLE only); op_i/dir_i/tx_data_i latched with it
//   op_i              0 = TX, 1 = RX
//   dir_i             0 = left shift (MSB first), 1 = right shift (LSB first)
//   tx_data_i         word to transmit
//   ser_i             RX serial input bit
//   p_i               parallel output of shift_reg
//   mode_o/d_o/par_o  shift_reg controls: mode (0 hold, 1 load, 2 left, 3 right), serial fill, load word
//   ser_o             TX serial output bit
//   busy_o, done_o    status: not IDLE / one-cycle DONE pulse
//   rx_data_o         last received word
module shift_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start_i,
   input  logic             op_i,
   input  logic             dir_i,
   input  logic [WIDTH-1:0] tx_data_i,
   input  logic             ser_i,
   input  logic [WIDTH-1:0] p_i,
   output logic [1:0]       mode_o,
   output logic             d_o,
   output logic [WIDTH-1:0] par_o,
   output logic             ser_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] rx_data_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] MODE_HOLD = 2'd0;
   localparam logic [1:0] MODE_LOAD = 2'd1;
   localparam logic [1:0] MODE_SHL  = 2'd2;
   localparam logic [1:0] MODE_SHR  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   logic             op_q;   // 1 = RX
   logic             dir_q;  // 1 = right shift
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= IDLE;
         op_q      <= 1'b0;
         dir_q     <= 1'b0;
         par_o     <= '0;
         cnt       <= '0;
         rx_data_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  op_q  <= op_i;
                  dir_q <= dir_i;
                  par_o <= tx_data_i;
                  cnt   <= '0;
                  // RX has nothing to preload, so it goes straight to shifting
                  state <= op_i ? SHIFT : LOAD;
               end
            end
            LOAD: state <= SHIFT;
            SHIFT: begin
               // counter ends at WIDTH after the last shift and stays there until the next start
               cnt <= cnt + CNT_ONE;
               if (cnt == CNT_LAST) state <= DONE;
            end
            DONE: begin
               // shift_reg holds the assembled word while in DONE
               if (op_q) rx_data_o <= p_i;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      mode_o = MODE_HOLD;
      d_o    = 1'b0;
      ser_o  = 1'b0;
      done_o = 1'b0;
      busy_o = (state != IDLE);
      case (state)
         LOAD: mode_o = MODE_LOAD;
         SHIFT: begin
            mode_o = dir_q ? MODE_SHR : MODE_SHL;
            if (op_q) begin
               d_o = ser_i;
            end else begin
               // TX zero-fills; the outgoing bit is the one about to fall off the shifting end
               ser_o = dir_q ? p_i[0] : p_i[WIDTH-1];
            end
         end
         DONE: done_o = 1'b1;
         default: ;
      endcase
   end

endmodule
